// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host receiver.
//   ps2_state_e     receiver FSM states
//   PS2_DATA_BITS   data bits per frame
//   PS2_FRAME_BITS  total bits per frame (start + data + parity + stop)
//   ps2_odd_parity  parity bit that makes data+parity carry an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// ps2_sync: N-stage synchronizer for the PS/2 clock and data lines plus a
// one-cycle falling-edge strobe on the synchronized clock.
//   clk, rst_n   system clock, async active-low reset
//   ps2_clk/dat  raw asynchronous pad inputs (idle high)
//   fall         one-cycle strobe, SYNC_STAGES+1 cycles after raw clock fall
//   dat          synchronized data, aligned with fall
module ps2_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall,
  output logic dat
);

  logic [SYNC_STAGES-1:0] clk_sr, dat_sr;
  logic                   clk_d;

  // The edge detector is registered, so data gets one extra flop to stay
  // aligned with the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sr <= '1;
      dat_sr <= '1;
      clk_d  <= 1'b1;
      fall   <= 1'b0;
      dat    <= 1'b1;
    end else begin
      clk_sr <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
      dat_sr <= {dat_sr[SYNC_STAGES-2:0], ps2_dat};
      clk_d  <= clk_sr[SYNC_STAGES-1];
      fall   <= clk_d & ~clk_sr[SYNC_STAGES-1];
      dat    <= dat_sr[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 host-side frame receiver with one-entry valid/ready output.
//   clk, rst_n        system clock, async active-low reset
//   ps2_clk, ps2_dat  raw PS/2 lines
//   out_data/valid/ready  received byte handshake
//   parity_err, frame_err, overrun, timeout_err  one-cycle error pulses
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       timeout_err
);

  localparam int              TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [2:0]      LAST = 3'(PS2_DATA_BITS - 1);

  logic       fall, dat;
  ps2_state_e state, state_n;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par;
  logic [TW-1:0] tcnt;
  logic       shift_en, par_en, eval, tout, start;
  logic       good, load;

  ps2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .fall    (fall),
    .dat     (dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // A falling edge counts as progress, so it beats a timeout in the same cycle.
  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    par_en   = 1'b0;
    eval     = 1'b0;
    tout     = 1'b0;
    start    = 1'b0;
    if (state != IDLE && !fall && tcnt == TMAX) begin
      state_n = IDLE;
      tout    = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE:   if (!dat) begin state_n = DATA; start = 1'b1; end
        DATA:   begin shift_en = 1'b1; if (bit_cnt == LAST) state_n = PARITY; end
        PARITY: begin par_en = 1'b1; state_n = STOP; end
        STOP:   begin eval = 1'b1; state_n = IDLE; end
        default: state_n = IDLE;
      endcase
    end
  end

  // In STOP, dat is the stop bit; a low stop bit outranks a parity mismatch.
  assign good = eval & dat & (^{shreg, par});
  assign load = good & (~out_valid | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      tcnt        <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (start)         bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg <= {dat, shreg[7:1]};
      if (par_en)   par   <= dat;

      if (state == IDLE || fall) tcnt <= '0;
      else if (tcnt != TMAX)     tcnt <= tcnt + 1'b1;

      if (load) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      frame_err   <= eval & ~dat;
      parity_err  <= eval & dat & ~(^{shreg, par});
      overrun     <= good & out_valid & ~out_ready;
      timeout_err <= tout;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int TO = 200;   // timeout in cycles
  localparam int H  = 20;    // ps2_clk low time in cycles
  localparam int Q  = 10;    // half of ps2_clk high time

  logic clk = 0, rst_n = 0, ps2_clk = 1, ps2_dat = 1, out_ready = 0;
  logic [7:0] out_data;
  logic out_valid, parity_err, frame_err, overrun, timeout_err;

  int pass_cnt = 0, total = 0;
  int n_pe = 0, n_fe = 0, n_ov = 0, n_to = 0, viol = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  // Monitor: accepted bytes, pulse counts, and held-data stability.
  logic pv = 0, pr = 0, prst = 0;
  logic [7:0] pd = 0;
  always @(posedge clk) begin
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (parity_err)  n_pe <= n_pe + 1;
    if (frame_err)   n_fe <= n_fe + 1;
    if (overrun)     n_ov <= n_ov + 1;
    if (timeout_err) n_to <= n_to + 1;
    if (rst_n && prst && pv && !pr && out_data !== pd) viol <= viol + 1;
    pv <= out_valid; pr <= out_ready; pd <= out_data; prst <= rst_n;
  end

  // Reference classification: 0 good, 1 parity error, 2 framing error.
  function automatic int classify(input logic [7:0] d, input logic p, input logic s);
    if (!s) return 2;
    if ($countones({d, p}) % 2 == 1) return 0;
    return 1;
  endfunction

  task automatic send_bit(input logic b);
    ps2_dat = b;
    repeat (Q) @(negedge clk);
    ps2_clk = 0;
    repeat (H) @(negedge clk);
    ps2_clk = 1;
    repeat (Q) @(negedge clk);
  endtask

  // Sends the first nbits of a frame. On the stop bit, lat is the number of
  // cycles until out_valid shows d; ready_at pulses out_ready for one cycle.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int nbits, input int ready_at, output int lat);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      if (i == 10) begin
        ps2_dat = f[i];
        repeat (Q) @(negedge clk);
        ps2_clk = 0;
        for (int j = 1; j <= H; j++) begin
          @(negedge clk);
          if (lat < 0 && out_valid && out_data == d) lat = j;
          if (j == ready_at) out_ready = 1;
          else if (j == ready_at + 1) out_ready = 0;
        end
        ps2_clk = 1;
        repeat (Q) @(negedge clk);
      end else begin
        send_bit(f[i]);
      end
    end
    ps2_dat = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, out_data, parity_err, frame_err, overrun, timeout_err} !== 13'd0)
      $display("FAIL reset_outputs got=%b want=0",
               {out_valid, out_data, parity_err, frame_err, overrun, timeout_err});
    else pass_cnt++;
    rst_n = 1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int lat, e0;
    out_ready = 0;
    got_q.delete();
    e0 = n_pe + n_fe + n_ov + n_to;
    send_frame(8'hA5, 1'b1, 1'b1, 11, -1, lat);
    total++;
    if (!(lat >= 1 && lat <= 4)) $display("FAIL good_latency got=%0d want=1..4", lat);
    else pass_cnt++;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5)
      $display("FAIL good_hold got=%b/%h want=1/a5", out_valid, out_data);
    else pass_cnt++;
    total++;
    if (n_pe + n_fe + n_ov + n_to != e0)
      $display("FAIL good_no_err got=%0d want=%0d", n_pe + n_fe + n_ov + n_to, e0);
    else pass_cnt++;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    total++;
    if (out_valid !== 1'b0 || got_q.size() != 1 || got_q[0] !== 8'hA5)
      $display("FAIL good_drain valid=%b accepted=%0d want valid=0 accepted=1",
               out_valid, got_q.size());
    else pass_cnt++;
  endtask

  task automatic test_random_good();
    int lat, e0, bad;
    logic [7:0] d;
    out_ready = 1;
    got_q.delete(); exp_q.delete();
    e0 = n_pe + n_fe + n_ov + n_to;
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send_frame(d, ($countones(d) % 2 == 0), 1'b1, 11, -1, lat);
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    total++;
    if (got_q.size() != 16) $display("FAIL rand_count got=%0d want=16", got_q.size());
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 16 && k < got_q.size(); k++) if (got_q[k] !== exp_q[k]) bad++;
    total++;
    if (bad != 0) $display("FAIL rand_order mismatched=%0d want=0", bad);
    else pass_cnt++;
    total++;
    if (n_pe + n_fe + n_ov + n_to != e0)
      $display("FAIL rand_no_err got=%0d want=%0d", n_pe + n_fe + n_ov + n_to, e0);
    else pass_cnt++;
  endtask

  task automatic test_random_mixed();
    int lat, pe0, fe0, epe, efe, c, bad;
    logic [7:0] d; logic p, s;
    out_ready = 1;
    got_q.delete(); exp_q.delete();
    pe0 = n_pe; fe0 = n_fe; epe = 0; efe = 0;
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom); p = 1'($urandom); s = ($urandom_range(0, 3) != 0);
      c = classify(d, p, s);
      if (c == 0) exp_q.push_back(d);
      else if (c == 1) epe++;
      else efe++;
      send_frame(d, p, s, 11, -1, lat);
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) if (got_q[k] !== exp_q[k]) bad++;
    total++;
    if (bad != 0) $display("FAIL mixed_bytes got=%0d want=%0d bad=%0d", got_q.size(), exp_q.size(), bad);
    else pass_cnt++;
    total++;
    if (n_pe - pe0 != epe || n_fe - fe0 != efe)
      $display("FAIL mixed_errs pe=%0d fe=%0d want pe=%0d fe=%0d", n_pe - pe0, n_fe - fe0, epe, efe);
    else pass_cnt++;
  endtask

  task automatic test_bad_frames();
    int lat, pe0, fe0;
    out_ready = 1;
    got_q.delete();
    pe0 = n_pe; fe0 = n_fe;
    send_frame(8'h01, 1'b1, 1'b1, 11, -1, lat);
    total++;
    if (n_pe - pe0 != 1 || n_fe != fe0 || got_q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL bad_parity pe=%0d fe=%0d bytes=%0d want 1/0/0", n_pe - pe0, n_fe - fe0, got_q.size());
    else pass_cnt++;
    send_frame(8'h01, 1'b0, 1'b0, 11, -1, lat);
    total++;
    if (n_fe - fe0 != 1 || n_pe - pe0 != 1 || got_q.size() != 0)
      $display("FAIL bad_stop fe=%0d pe=%0d bytes=%0d want 1/1/0", n_fe - fe0, n_pe - pe0, got_q.size());
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int lat, ov0;
    out_ready = 0;
    got_q.delete();
    ov0 = n_ov;
    send_frame(8'h12, 1'b1, 1'b1, 11, -1, lat);
    send_frame(8'h34, 1'b0, 1'b1, 11, -1, lat);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h12 || n_ov - ov0 != 1)
      $display("FAIL overrun_hold got=%b/%h ov=%0d want 1/12 ov=1", out_valid, out_data, n_ov - ov0);
    else pass_cnt++;
    out_ready = 1; @(negedge clk); out_ready = 0;
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h12 || out_valid !== 1'b0)
      $display("FAIL overrun_drain bytes=%0d valid=%b want 1/0", got_q.size(), out_valid);
    else pass_cnt++;
    // Accept 0x12 in the very cycle 0x34 completes.
    got_q.delete();
    ov0 = n_ov;
    send_frame(8'h12, 1'b1, 1'b1, 11, -1, lat);
    send_frame(8'h34, 1'b0, 1'b1, 11, 3, lat);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h34 || n_ov != ov0 || lat != 4)
      $display("FAIL swap_load got=%b/%h ov=%0d lat=%0d want 1/34 ov=0 lat=4",
               out_valid, out_data, n_ov - ov0, lat);
    else pass_cnt++;
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h12)
      $display("FAIL swap_accept bytes=%0d want 1 (12)", got_q.size());
    else pass_cnt++;
    out_ready = 1; @(negedge clk); out_ready = 0;
  endtask

  task automatic test_timeout();
    int lat, to0, e0;
    out_ready = 1;
    got_q.delete();
    to0 = n_to; e0 = n_pe + n_fe + n_ov;
    send_frame(8'($urandom), 1'b0, 1'b1, 5, -1, lat);
    repeat (TO + 10) @(negedge clk);
    total++;
    if (n_to - to0 != 1) $display("FAIL timeout_pulse got=%0d want=1", n_to - to0);
    else pass_cnt++;
    send_frame(8'h5A, 1'b1, 1'b1, 11, -1, lat);
    repeat (5) @(negedge clk);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A || n_to - to0 != 1 || n_pe + n_fe + n_ov != e0)
      $display("FAIL timeout_recover bytes=%0d to=%0d want 1 (5a) to=1", got_q.size(), n_to - to0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, e0;
    out_ready = 1;
    got_q.delete();
    e0 = n_pe + n_fe + n_ov + n_to;
    send_frame(8'hC3, 1'b1, 1'b1, 6, -1, lat);
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, out_data, parity_err, frame_err, overrun, timeout_err} !== 13'd0)
      $display("FAIL midreset_outputs got=%b want=0",
               {out_valid, out_data, parity_err, frame_err, overrun, timeout_err});
    else pass_cnt++;
    rst_n = 1;
    repeat (5) @(negedge clk);
    send_frame(8'hFF, 1'b1, 1'b1, 11, -1, lat);
    repeat (5) @(negedge clk);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'hFF || n_pe + n_fe + n_ov + n_to != e0)
      $display("FAIL midreset_recover bytes=%0d errs=%0d want 1 (ff) errs=0",
               got_q.size(), n_pe + n_fe + n_ov + n_to - e0);
    else pass_cnt++;
  endtask

  task automatic test_spurious();
    int lat, e0;
    out_ready = 1;
    got_q.delete();
    e0 = n_pe + n_fe + n_ov + n_to;
    send_bit(1'b1);
    repeat (TO + 10) @(negedge clk);
    total++;
    if (n_pe + n_fe + n_ov + n_to != e0 || out_valid !== 1'b0)
      $display("FAIL spurious_quiet errs=%0d valid=%b want 0/0", n_pe + n_fe + n_ov + n_to - e0, out_valid);
    else pass_cnt++;
    send_frame(8'h3C, 1'b1, 1'b1, 11, -1, lat);
    repeat (5) @(negedge clk);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h3C)
      $display("FAIL spurious_next bytes=%0d want 1 (3c)", got_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_random_good();
    test_random_mixed();
    test_bad_frames();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_spurious();
    total++;
    if (viol != 0) $display("FAIL hold_stability changes=%0d want=0", viol);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
